// File: rtl/booth_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: digit encoding,
// FSM state type and the 3-bit multiplier window decoder.
package booth_pkg;

  // Booth digit selected from one overlapping 3-bit multiplier window
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // Controller states; visible as r_state inside booth_mul_seq
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Map {b[2i+1], b[2i], b[2i-1]} to the radix-4 digit
  function automatic digit_t booth_encode(input logic [2:0] bits);
    digit_t d;
    case (bits)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// Combinational partial-product generator for one radix-4 Booth digit.
// Produces the A_LEN+2-bit partial product; for negative digits it emits the
// bitwise inverse of the magnitude and raises o_neg, so the caller completes
// the two's complement negation through the adder carry-in.
module booth_digit_pp
  import booth_pkg::*;
#(
  parameter int A_LEN = 256
) (
  input  logic [A_LEN:0]   i_a,
  input  digit_t           i_dig,
  output logic [A_LEN+1:0] o_pp,
  output logic             o_neg
);

  logic [A_LEN+1:0] w_mag;

  // Select 0, A' or 2A' and invert it for negative digits
  always_comb begin
    w_mag = '0;
    o_neg = 1'b0;
    case (i_dig)
      POS1: w_mag = {i_a[A_LEN], i_a};
      POS2: w_mag = {i_a, 1'b0};
      NEG1: begin
        w_mag = {i_a[A_LEN], i_a};
        o_neg = 1'b1;
      end
      NEG2: begin
        w_mag = {i_a, 1'b0};
        o_neg = 1'b1;
      end
      default: w_mag = '0;
    endcase
    o_pp = o_neg ? ~w_mag : w_mag;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock,
// signed or unsigned operands selected per transaction.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE; out_valid is high only in DONE and
// out_prod stays constant until the edge where out_ready is seen high.
// busy is high in RUN and DONE.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter  int A_LEN = 256,
  parameter  int B_LEN = 64,
  localparam int P_LEN = A_LEN + B_LEN,
  localparam int N_DIG = B_LEN / 2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [A_LEN-1:0] in_a,
  input  logic [B_LEN-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_LEN-1:0] out_prod,
  output logic             busy
);

  localparam int ACC_W = P_LEN + 3;
  localparam int PP_W  = A_LEN + 2;
  localparam int CNT_W = $clog2(N_DIG + 1);

  state_t             r_state;
  state_t             w_next;
  logic [A_LEN:0]     r_a;      // A' = ext(in_a)
  logic [B_LEN+2:0]   r_b;      // {B', B'[-1]=0}, shifted right two bits per digit
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [P_LEN-1:0]   r_prod;

  logic               w_accept;
  logic               w_last;
  digit_t             w_dig;
  logic [PP_W-1:0]    w_pp;
  logic               w_neg;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_cin;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W:0]     w_shamt;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(N_DIG - 1));
  // Lowest three bits of the shifted multiplier are the current digit window
  assign w_dig    = booth_encode(r_b[2:0]);

  booth_digit_pp #(
    .A_LEN(A_LEN)
  ) u_pp (
    .i_a  (r_a),
    .i_dig(w_dig),
    .o_pp (w_pp),
    .o_neg(w_neg)
  );

  // Digit i carries weight 2^(2i); the negation +1 enters at the same weight
  assign w_shamt    = {r_cnt, 1'b0};
  assign w_addend   = {{(ACC_W - PP_W){w_pp[PP_W-1]}}, w_pp} << w_shamt;
  assign w_cin      = ACC_W'(w_neg) << w_shamt;
  assign w_acc_next = r_acc + w_addend + w_cin;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, digit accumulation and product capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_a    <= {in_signed & in_a[A_LEN-1], in_a};
      r_b    <= {{2{in_signed & in_b[B_LEN-1]}}, in_b, 1'b0};
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_acc  <= w_acc_next;
      r_cnt  <= r_cnt + CNT_W'(1);
      r_b    <= {2'b00, r_b[B_LEN+2:2]};
      if (w_last) r_prod <= w_acc_next[P_LEN-1:0];
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_prod  = r_prod;

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Iterative radix-4 Booth multiplier, parametrised in operand widths. Retires one Booth digit per clock.
- Supports signed and unsigned operands, selected per transaction.
- Uses valid/ready handshakes on the operand and result sides.
- Successor to the combinational partial-product generator. Sits between the operand staging logic and the wide-accumulate datapath; the default widths are the 256x64 configuration.

Parameters:
- A_LEN, 256, multiplicand width in bits; must be >= 2.
- B_LEN, 64, multiplier width in bits; must be even and >= 2.
- P_LEN, A_LEN+B_LEN, product width; derived, not to be overridden.
- N_DIG, B_LEN/2+1, Booth digits per operation; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- in_a  in  A_LEN  multiplicand.
- in_b  in  B_LEN  multiplier.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes the product.
- out_prod  out  P_LEN  exact product: signed or unsigned per the latched mode.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_prod=0, digit counter=0, accumulator=0.
  - rst=1 mid-RUN or in DONE aborts the operation.
  - The partial result is discarded, and out_valid drops on the cycle after the reset edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch A'=ext(in_a) to A_LEN+1 bits.
    - latch B'=ext(in_b) to B_LEN+2 bits.
    - ext is sign-extension when in_signed=1, zero-extension otherwise.
    - Implicit B'[-1]=0. Clear the accumulator and counter, go to RUN.
  - RUN: in_ready=0. Each cycle, digit i=counter is formed from B'[2i+1], B'[2i], B'[2i-1]:
    - 000/111 -> 0
    - 001/010 -> +A'
    - 011 -> +2A'
    - 100 -> -2A'
    - 101/110 -> -A'
    - Sign-extend the partial product to accumulator width, add at weight 2^(2i), increment the counter.
    - After the digit with i=N_DIG-1, latch out_prod = acc[P_LEN-1:0] and go to DONE.
  - DONE: out_valid=1 and out_prod stable until out_ready=1. Then go to IDLE with out_valid=0 on the next cycle.
    - in_ready stays 0 in DONE; there is no same-cycle accept.
- Latency:
  - The accept edge is followed by N_DIG RUN cycles. out_valid rises on the edge ending the last RUN cycle.
  - Default configuration: 33 cycles from the accept edge to out_valid.
  - Minimum issue interval is N_DIG+2 cycles with out_ready held at 1.
- Arithmetic:
  - Negation is two's complement (invert, add one), merged into the add through the carry-in.
  - The accumulator is at least P_LEN+3 bits wide. The truncation to P_LEN is exact for every operand pair in both modes.
  - Corner cases:
    - A=most-negative with digit -2 must not overflow the A_LEN+2-bit partial product.
    - Unsigned B with B[B_LEN-1]=1 is handled by the extra top digit.
- in_signed, in_a and in_b are sampled only at accept; later changes are ignored.
- out_valid=1 with out_ready=0 holds indefinitely with no change to out_prod.

Decomposition:
- Package booth_pkg holds:
  - the digit-encoding type: enum of ZERO, POS1, POS2, NEG1, NEG2;
  - the FSM state type;
  - the function mapping 3 multiplier bits to the digit encoding.
- Sub-module booth_digit_pp, combinational:
  - inputs: A' (A_LEN+1) and digit encoding.
  - outputs: the A_LEN+2-bit partial product magnitude/inverted form and the neg carry-in bit.
  - This is the generalised form of the existing partial-product generator; the FSM and accumulator stay in booth_mul_seq.

Test Plan:
- A_LEN=8, B_LEN=8, signed, a=0xFD (-3), b=0x05: after 5 RUN cycles out_prod=0xFFF1 (-15), out_valid held until out_ready.
- A_LEN=8, B_LEN=8, unsigned, a=0xFF, b=0xFF: out_prod=0xFE01 (65025). Signed with the same inputs: out_prod=0x0001.
- A_LEN=8, B_LEN=8, signed, a=0x80, b=0x80: out_prod=0x4000. Also a=0x80, b=0x7F: out_prod=0xC080 (-16256).
- Default config, signed, a=-1 (all ones), b=2^63-1: out_prod=-(2^63-1) sign-extended to 320 bits, out_valid exactly 33 cycles after accept. Back-to-back issue gives in_ready=0 throughout RUN/DONE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE; out_prod is unchanged, in_ready stays 0, and the next accept occurs only after out_ready=1.
- Reset: assert rst for 1 cycle at RUN digit 3. Next cycle IDLE, in_ready=1, out_valid=0. A fresh transaction then yields the correct product with no residue.
